// File: rtl/mem_txn_driver.sv
// Request FIFO feeding a single-outstanding memory sequencer: writes take one
// strobe cycle, reads strobe, capture the returned data, then hold a response.
module mem_txn_driver #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic [7:0]        wr_cnt,
    output logic [7:0]        rd_cnt
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, RESP} state_t;

    state_t        state, state_nx;
    req_t          fifo [DEPTH];
    req_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop;

    assign req_ready = (count < (PW+1)'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = fifo[rd_ptr];
    assign busy      = (count != '0) || (state != IDLE);
    assign rsp_valid = (state == RESP);

    // Storage carries no reset; occupancy is governed solely by count.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{write: req_write, addr: req_addr, data: req_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = head.write ? WR : RD;
            WR:      state_nx = IDLE;
            RD:      state_nx = CAP;
            CAP:     state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are registered copies of the upcoming state, so they are high
    // exactly during WR / RD; mem_addr holds the entry address through CAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rsp_addr    <= '0;
            rsp_data    <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
        end else begin
            mem_write <= (state_nx == WR);
            mem_read  <= (state_nx == RD);
            if (pop) begin
                mem_addr <= head.addr;
                if (head.write) mem_data_in <= head.data;
            end
            if (state == CAP) begin
                rsp_data <= mem_data_out;
                rsp_addr <= mem_addr;
            end
            if (state == WR)               wr_cnt <= wr_cnt + 8'd1;
            if (state == RESP && rsp_ready) rd_cnt <= rd_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_mem_txn_driver.sv
// Directed bench for mem_txn_driver with a one-cycle-latency memory model.
module tb_mem_txn_driver;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready, rsp_valid, mem_write, mem_read, busy;
    logic [AW-1:0] rsp_addr, mem_addr;
    logic [DW-1:0] rsp_data, mem_data_in;
    logic [DW-1:0] mem_data_out = '0;
    logic [7:0]    wr_cnt, rd_cnt;
    logic [DW-1:0] mem [32];

    int checks = 0;
    int errors = 0;
    bit strobe_both = 1'b0;

    mem_txn_driver #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_read(mem_read), .mem_data_out(mem_data_out),
        .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read)  mem_data_out <= mem[mem_addr];
    end

    always @(negedge clk) if (mem_read && mem_write) strobe_both = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    task automatic push(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        ok = 1'b0;
        req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            else cyc();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_timeout: req_ready stayed %b, wanted 1", req_ready);
        end else cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (rsp_valid) ok = 1'b1;
            else cyc();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no rsp_valid within 100 cycles", name);
        end else if (rsp_addr !== a || rsp_data !== d) begin
            errors++;
            $display("FAIL %s: got addr=%0d data=%h, wanted addr=%0d data=%h",
                     name, rsp_addr, rsp_data, a, d);
        end
        if (ok) begin
            rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!busy) ok = 1'b1;
            else cyc();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%b, wanted 0", busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b rsp_valid=%b busy=%b, wanted 1 0 0", req_ready, rsp_valid, busy);
        end
        checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || wr_cnt !== 8'd0 || rd_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctl: mw=%b mr=%b wr=%0d rd=%0d, wanted all 0", mem_write, mem_read, wr_cnt, rd_cnt);
        end
        checks++;
        if (mem_addr !== '0 || mem_data_in !== '0 || rsp_addr !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_data: ma=%0d md=%h ra=%0d rd=%h, wanted 0", mem_addr, mem_data_in, rsp_addr, rsp_data);
        end
    endtask

    task automatic test_write_read();
        push(1'b1, 5'd3, 8'hA5);
        push(1'b0, 5'd3, 8'h00);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 5'd3 || mem_data_in !== 8'hA5) begin
            errors++;
            $display("FAIL wr_strobe: mw=%b mr=%b addr=%0d data=%h, wanted 1 0 3 a5", mem_write, mem_read, mem_addr, mem_data_in);
        end
        cyc();
        checks++;
        if (mem_write !== 1'b0 || wr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL wr_done: mw=%b wr_cnt=%0d, wanted 0 1", mem_write, wr_cnt);
        end
        cyc();
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 5'd3) begin
            errors++;
            $display("FAIL rd_strobe: mr=%b mw=%b addr=%0d, wanted 1 0 3", mem_read, mem_write, mem_addr);
        end
        wait_rsp(5'd3, 8'hA5, "wr_rd_rsp");
        checks++;
        if (rd_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rd_cnt1: got %0d, wanted 1", rd_cnt);
        end
    endtask

    task automatic test_full();
        bit stuck_ok;
        push(1'b0, 5'd3, 8'h00);
        push(1'b1, 5'd20, 8'h11);
        push(1'b1, 5'd21, 8'h22);
        push(1'b1, 5'd22, 8'h33);
        push(1'b1, 5'd23, 8'h44);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_ready: ready=%b rsp_valid=%b, wanted 0 1", req_ready, rsp_valid);
        end
        stuck_ok = 1'b1;
        req_write = 1'b1; req_addr = 5'd24; req_data = 8'h55; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (req_ready !== 1'b0) stuck_ok = 1'b0;
            cyc();
        end
        req_valid = 1'b0;
        checks++;
        if (!stuck_ok) begin
            errors++;
            $display("FAIL full_hold: req_ready rose while full, wanted 0");
        end
        wait_rsp(5'd3, 8'hA5, "full_rsp");
        wait_idle();
        checks++;
        if (wr_cnt !== 8'd5) begin
            errors++;
            $display("FAIL full_no_sixth: wr_cnt=%0d, wanted 5", wr_cnt);
        end
        push(1'b1, 5'd24, 8'h55);
        push(1'b0, 5'd20, 8'h00);
        wait_rsp(5'd20, 8'h11, "full_rd20");
        push(1'b0, 5'd24, 8'h00);
        wait_rsp(5'd24, 8'h55, "full_rd24");
        wait_idle();
        checks++;
        if (wr_cnt !== 8'd6 || rd_cnt !== 8'd4) begin
            errors++;
            $display("FAIL full_cnt: wr=%0d rd=%0d, wanted 6 4", wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        push(1'b0, 5'd3, 8'h00);
        push(1'b1, 5'd5, 8'h66);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rsp_valid) ok = 1'b1;
            else cyc();
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_addr !== 5'd3 || rsp_data !== 8'hA5 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable: cyc %0d v=%b a=%0d d=%h mr=%b mw=%b, wanted 1 3 a5 0 0",
                         i, rsp_valid, rsp_addr, rsp_data, mem_read, mem_write);
            end
            cyc();
        end
        wait_rsp(5'd3, 8'hA5, "bp_rsp");
        wait_idle();
        checks++;
        if (wr_cnt !== 8'd7 || rd_cnt !== 8'd5) begin
            errors++;
            $display("FAIL bp_cnt: wr=%0d rd=%0d, wanted 7 5", wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_sweep();
        logic [AW-1:0] a;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            a = AW'(i);
            push(1'b1, a, DW'(i));
        end
        for (int i = 0; i < 32; i++) begin
            a = AW'(i);
            push(1'b0, a, 8'h00);
            wait_rsp(a, DW'(i), "sweep_rd");
        end
        wait_idle();
        checks++;
        if (wr_cnt !== 8'd32 || rd_cnt !== 8'd32) begin
            errors++;
            $display("FAIL sweep_cnt: wr=%0d rd=%0d, wanted 32 32", wr_cnt, rd_cnt);
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok, quiet;
        push(1'b0, 5'd7, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_read) ok = 1'b1;
            else cyc();
        end
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if (!ok || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || wr_cnt !== 8'd0 || rd_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: seen_rd=%b v=%b busy=%b ready=%b wr=%0d rd=%0d, wanted 1 0 0 1 0 0",
                     ok, rsp_valid, busy, req_ready, wr_cnt, rd_cnt);
        end
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid || mem_read || mem_write || busy) quiet = 1'b0;
            cyc();
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mid_reset_quiet: activity after reset, wanted none");
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 255; i++) push(1'b1, AW'(i), DW'(i));
        wait_idle();
        checks++;
        if (wr_cnt !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: wr_cnt=%0d, wanted 255", wr_cnt);
        end
        push(1'b1, 5'd31, 8'hFF);
        wait_idle();
        checks++;
        if (wr_cnt !== 8'd0 || rd_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0: wr=%0d rd=%0d, wanted 0 0", wr_cnt, rd_cnt);
        end
        push(1'b0, 5'd31, 8'h00);
        wait_rsp(5'd31, 8'hFF, "wrap_rd31");
        checks++;
        if (strobe_both !== 1'b0) begin
            errors++;
            $display("FAIL strobe_excl: mem_read and mem_write seen together=%b, wanted 0", strobe_both);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_full();
        test_backpressure();
        test_sweep();
        test_reset_mid_read();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_txn_driver.md
MEM_TXN_DRIVER -- requirements
Module: mem_txn_driver

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 5, memory address width.
- DATA_W, default 8, memory data width.
- DEPTH, default 4, request FIFO depth (power of 2, >=2).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request FIFO can accept.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_data  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_addr  out  ADDR_W  address of the read.
- rsp_data  out  DATA_W  data read.
- mem_addr  out  ADDR_W  to memory addr.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_write  out  1  to memory write strobe.
- mem_read  out  1  to memory read strobe.
- mem_data_out  in  DATA_W  from memory; valid one cycle after a mem_read cycle.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- wr_cnt  out  8  writes issued, wraps 255->0.
- rd_cnt  out  8  read responses delivered, wraps 255->0.

REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 Handshake rules:
- A request SHALL be pushed on any edge with req_valid && req_ready.
- req_ready SHALL be 1 exactly when FIFO count < DEPTH.
- When full, no push SHALL occur even if a pop happens on the same edge.

REQ-005 FSM states SHALL be IDLE, WR, RD, CAP and RESP.

REQ-006 IDLE behaviour: when the FIFO is non-empty, the block SHALL pop the head entry. It SHALL go to WR for a write entry and to RD for a read entry. With an empty FIFO it SHALL stay in IDLE.

REQ-007 WR SHALL last exactly 1 cycle, with mem_write=1, mem_addr and mem_data_in taken from the entry. It SHALL then return to IDLE, and wr_cnt SHALL increment on that edge.

REQ-008 RD SHALL last exactly 1 cycle, with mem_read=1 and mem_addr taken from the entry. It SHALL then go to CAP.

REQ-009 CAP SHALL last 1 cycle. On its closing edge, rsp_data SHALL load mem_data_out and rsp_addr SHALL load the entry address, and the FSM SHALL go to RESP.

REQ-010 RESP behaviour:
- rsp_valid SHALL be 1, and rsp_addr and rsp_data SHALL be stable until rsp_ready=1.
- On the handshake edge the FSM SHALL go to IDLE and rd_cnt SHALL increment.

REQ-011 Strobe rules:
- mem_write and mem_read SHALL be registered and SHALL never both be 1.
- Both SHALL be 0 in IDLE, CAP and RESP.

REQ-012 Memory operations SHALL be issued strictly in FIFO order, one at a time. Minimum spacing SHALL be 2 cycles per write and 3 cycles plus response wait per read.

REQ-013 Pushes SHALL continue during any FSM state while not full, including simultaneous push and pop.

REQ-014 busy SHALL be combinational from FIFO count and state.

Reset
REQ-015 While rst_n=0 at a clock edge:
- FSM SHALL go to IDLE.
- FIFO SHALL be emptied, so req_ready=1 after reset.
- rsp_valid, mem_read, mem_write, wr_cnt and rd_cnt SHALL be 0.
- mem_addr, mem_data_in, rsp_addr and rsp_data SHALL be 0.

REQ-016 Reset mid-operation SHALL discard queued and in-flight requests, and no response SHALL be produced for them.

Verification
REQ-017 Write then read: push W(3,0xA5) then R(3) -> mem_write=1 with addr 3 and data 0xA5 for one cycle. mem_read=1 follows, and rsp_valid rises with rsp_addr=3, rsp_data=0xA5; wr_cnt=1, rd_cnt=1.

REQ-018 Full FIFO: hold rsp_ready=0 and push 1 read plus 4 writes -> req_ready=0 after the FIFO is full. A 6th request SHALL not be accepted until the FIFO drains.

REQ-019 Backpressure: response pending with rsp_ready=0 for 10 cycles -> rsp_valid, rsp_addr and rsp_data stay stable. No mem strobe occurs until the handshake.

REQ-020 Sweep: write data=addr to addresses 0..31, then read 0..31 -> rsp_data==rsp_addr for all 32 reads, in order. wr_cnt=32, rd_cnt=32.

REQ-021 Reset mid-read: assert rst_n=0 during CAP -> next cycle rsp_valid=0, busy=0, req_ready=1, counters 0. No response follows.

REQ-022 Counter wrap: perform 256 writes -> wr_cnt returns to 0. Every cycle, mem_read && mem_write is never 1.
